// File: rtl/dram_pkg.sv
// Command encodings, FSM states and default DRAM timing shared by the scheduler and its bench.
package dram_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_PRE_WAIT, S_ACT_WAIT, S_RD_WAIT, S_RESP,
    S_REF_PRE, S_REF_PRE_WAIT, S_REF_WAIT
  } state_t;

  localparam int T_RP_DEF   = 3;
  localparam int T_RCD_DEF  = 3;
  localparam int T_CL_DEF   = 4;
  localparam int T_RFC_DEF  = 8;
  localparam int T_REFI_DEF = 1000;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dram_addr_translator.sv
// Splits a byte address into {bank, row, col}, column in the LSBs; purely combinational.
module dram_addr_translator
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 20,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
) (
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  output logic [$clog2(NUM_OF_BANKS)-1:0] bank_o,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  row_o,
  output logic [$clog2(NUM_OF_COLS)-1:0]  col_o
);
  localparam int BW  = $clog2(NUM_OF_BANKS);
  localparam int RW  = $clog2(NUM_OF_ROWS);
  localparam int CW  = $clog2(NUM_OF_COLS);
  localparam int MSB = BW + RW + CW;

  logic unused_hi;

  assign col_o  = addr_i[CW-1:0];
  assign row_o  = addr_i[CW+RW-1:CW];
  assign bank_o = addr_i[MSB-1:CW+RW];
  assign unused_hi = ^addr_i[ADDR_WIDTH-1:MSB];

endmodule

// File: rtl/dram_bank_scheduler.sv
// One-request-at-a-time open-page DRAM sequencer: hit RD/WR 1 cycle after accept, closed +T_RCD, conflict +T_RP+T_RCD.
// req_ready only in IDLE with no refresh pending; responses are single-cycle pulses with no backpressure.
module dram_bank_scheduler
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RP         = T_RP_DEF,
  parameter int T_RCD        = T_RCD_DEF,
  parameter int T_CL         = T_CL_DEF,
  parameter int T_RFC        = T_RFC_DEF,
  parameter int T_REFI       = T_REFI_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic                            req_we,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  output logic                            resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic [2:0]                      dram_cmd,
  output logic                            dram_all_banks,
  output logic [$clog2(NUM_OF_BANKS)-1:0] dram_bank,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  dram_row,
  output logic [$clog2(NUM_OF_COLS)-1:0]  dram_col,
  output logic [DATA_WIDTH-1:0]           dram_wdata,
  input  logic [DATA_WIDTH-1:0]           dram_rdata
);
  localparam int BW   = $clog2(NUM_OF_BANKS);
  localparam int RW   = $clog2(NUM_OF_ROWS);
  localparam int CW   = $clog2(NUM_OF_COLS);
  localparam int TW   = $clog2(max4(T_RP, T_RCD, T_CL, T_RFC)) + 1;
  localparam int CNTW = $clog2(T_REFI);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [TW-1:0]           tmr_q;
  logic [NUM_OF_BANKS-1:0] open_vld_q;
  logic [RW-1:0]           open_row_q [NUM_OF_BANKS];
  logic [CNTW-1:0]         ref_cnt_q, ref_cnt_d;
  logic                    ref_pend_q, ref_set, ready_d, row_hit;

  logic                    req_ready_q, resp_valid_q, dram_all_banks_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, dram_wdata_q;
  logic [2:0]              dram_cmd_q;
  logic [BW-1:0]           dram_bank_q, bank;
  logic [RW-1:0]           dram_row_q, row;
  logic [CW-1:0]           dram_col_q, col;

  dram_addr_translator #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_OF_BANKS(NUM_OF_BANKS),
    .NUM_OF_ROWS (NUM_OF_ROWS),
    .NUM_OF_COLS (NUM_OF_COLS)
  ) u_xlat (
    .addr_i(addr_q),
    .bank_o(bank),
    .row_o (row),
    .col_o (col)
  );

  // Pending is raised in the same edge the counter reaches T_REFI-1, so req_ready is already low then.
  always_comb begin
    ref_cnt_d = (ref_cnt_q == CNTW'(T_REFI - 1)) ? '0 : ref_cnt_q + 1'b1;
    ref_set   = (ref_cnt_d == CNTW'(T_REFI - 1));
    ready_d   = !(ref_pend_q || ref_set);
    row_hit   = open_vld_q[bank] && (open_row_q[bank] == row);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      tmr_q            <= '0;
      open_vld_q       <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) open_row_q[b] <= '0;
      ref_cnt_q        <= '0;
      ref_pend_q       <= 1'b0;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      dram_cmd_q       <= CMD_NOP;
      dram_all_banks_q <= 1'b0;
      dram_bank_q      <= '0;
      dram_row_q       <= '0;
      dram_col_q       <= '0;
      dram_wdata_q     <= '0;
    end else begin
      dram_cmd_q       <= CMD_NOP;
      dram_all_banks_q <= 1'b0;
      resp_valid_q     <= 1'b0;
      req_ready_q      <= 1'b0;
      ref_cnt_q        <= ref_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (ref_pend_q) begin
            state_q <= S_REF_PRE;
          end else if (req_valid && req_ready_q) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            state_q <= S_CHECK;
          end else begin
            req_ready_q <= ready_d;
          end
        end
        S_CHECK: begin
          dram_bank_q <= bank;
          if (row_hit) begin
            dram_cmd_q   <= we_q ? CMD_WR : CMD_RD;
            dram_col_q   <= col;
            dram_wdata_q <= wdata_q;
            tmr_q        <= TW'(T_CL - 1);
            state_q      <= we_q ? S_RESP : S_RD_WAIT;
          end else if (open_vld_q[bank]) begin
            dram_cmd_q       <= CMD_PRE;
            open_vld_q[bank] <= 1'b0;
            tmr_q            <= TW'(T_RP - 1);
            state_q          <= S_PRE_WAIT;
          end else begin
            dram_cmd_q       <= CMD_ACT;
            dram_row_q       <= row;
            open_vld_q[bank] <= 1'b1;
            open_row_q[bank] <= row;
            tmr_q            <= TW'(T_RCD - 1);
            state_q          <= S_ACT_WAIT;
          end
        end
        S_PRE_WAIT: begin
          if (tmr_q == '0) begin
            dram_cmd_q       <= CMD_ACT;
            dram_bank_q      <= bank;
            dram_row_q       <= row;
            open_vld_q[bank] <= 1'b1;
            open_row_q[bank] <= row;
            tmr_q            <= TW'(T_RCD - 1);
            state_q          <= S_ACT_WAIT;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_ACT_WAIT: begin
          if (tmr_q == '0) begin
            dram_cmd_q   <= we_q ? CMD_WR : CMD_RD;
            dram_bank_q  <= bank;
            dram_col_q   <= col;
            dram_wdata_q <= wdata_q;
            tmr_q        <= TW'(T_CL - 1);
            state_q      <= we_q ? S_RESP : S_RD_WAIT;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (tmr_q == '0) state_q <= S_RESP;
          else             tmr_q   <= tmr_q - 1'b1;
        end
        // dram_rdata is valid during this state for reads; it is sampled at the edge that leaves it.
        S_RESP: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= we_q ? '0 : dram_rdata;
          req_ready_q  <= ready_d;
          state_q      <= S_IDLE;
        end
        S_REF_PRE, S_REF_PRE_WAIT: begin
          if (state_q == S_REF_PRE && open_vld_q != '0) begin
            dram_cmd_q       <= CMD_PRE;
            dram_all_banks_q <= 1'b1;
            tmr_q            <= TW'(T_RP - 1);
            state_q          <= S_REF_PRE_WAIT;
          end else if (state_q == S_REF_PRE || tmr_q == '0) begin
            dram_cmd_q <= CMD_REF;
            open_vld_q <= '0;
            ref_pend_q <= 1'b0;
            tmr_q      <= TW'(T_RFC - 1);
            state_q    <= S_REF_WAIT;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_REF_WAIT: begin
          if (tmr_q == '0) begin
            req_ready_q <= ready_d;
            state_q     <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (ref_set) ref_pend_q <= 1'b1;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign dram_cmd       = dram_cmd_q;
  assign dram_all_banks = dram_all_banks_q;
  assign dram_bank      = dram_bank_q;
  assign dram_row       = dram_row_q;
  assign dram_col       = dram_col_q;
  assign dram_wdata     = dram_wdata_q;

endmodule
